// File: rtl/dcache_pkg.sv
// dcache_pkg: shared definitions for the L1 data-cache controller.
//   - address field widths/offsets and tag-word bit positions
//   - controller state encoding
//   - word_select / word_merge helpers for 32-bit words inside a 256-bit line
package dcache_pkg;

   localparam int LINE_W    = 256;
   localparam int WORD_W    = 32;
   localparam int WSEL_W    = 3;   // 8 words per line
   localparam int OFFSET_W  = 5;   // byte offset within a line
   localparam int IDX_W     = 4;
   localparam int TAG_W     = 23;
   localparam int TAGWORD_W = 25;  // {valid, dirty, tag}
   localparam int VALID_BIT = 24;
   localparam int DIRTY_BIT = 23;

   typedef logic [2:0] state_t;

   localparam state_t S_IDLE        = 3'd0;
   localparam state_t S_MISS        = 3'd1;
   localparam state_t S_WRITEBACK   = 3'd2;
   localparam state_t S_REFILL      = 3'd3;
   localparam state_t S_REFILL_DONE = 3'd4;

   // Extract 32-bit word 'sel' from a line.
   function automatic logic [WORD_W-1:0] word_select(input logic [LINE_W-1:0] line,
                                                     input logic [WSEL_W-1:0] sel);
      return line[{sel, 5'b0} +: WORD_W];
   endfunction

   // Return 'line' with word 'sel' replaced by 'data'.
   function automatic logic [LINE_W-1:0] word_merge(input logic [LINE_W-1:0] line,
                                                    input logic [WSEL_W-1:0] sel,
                                                    input logic [WORD_W-1:0] data);
      logic [LINE_W-1:0] merged;
      merged = line;
      merged[{sel, 5'b0} +: WORD_W] = data;
      return merged;
   endfunction

endpackage

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: write-back, write-allocate controller for the 2-way L1 data cache.
// Hits are serviced combinationally through the SRAM; misses stall the CPU while
// an optional dirty-victim write-back and a line refill are sequenced.
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   cpu_req_i/we_i/addr_i   CPU request (addr: tag [31:9], index [8:5], word [4:2])
//   cpu_data_i/cpu_data_o   store data / load data
//   cpu_stall_o             CPU must hold its request
//   sram_*_o                SRAM enable, write strobe, set index, {v,d,tag}, line
//   sram_tag_i/data_i/hit_i SRAM lookup result (victim way on a miss)
//   mem_enable_o            one-cycle memory request pulse
//   mem_write_o/addr_o/data_o  write-back (1) or refill (0), line address, line
//   mem_data_i, mem_ack_i   refill line and one-cycle completion pulse
//   state_o                 current FSM state (debug visibility)
//
// Handshake: mem_enable_o pulses for the first cycle of WRITEBACK/REFILL; the FSM
// then waits for mem_ack_i, which is accepted from that same first cycle onward.
// Acks seen in any other state are ignored.
module dcache_ctrl
   import dcache_pkg::*;
#(
   parameter int LINE_BITS = 256,
   parameter int IDX_BITS  = 4,
   parameter int TAG_BITS  = 23
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  cpu_req_i,
   input  logic                  cpu_we_i,
   input  logic [31:0]           cpu_addr_i,
   input  logic [31:0]           cpu_data_i,
   output logic [31:0]           cpu_data_o,
   output logic                  cpu_stall_o,
   output logic                  sram_enable_o,
   output logic                  sram_write_o,
   output logic [IDX_BITS-1:0]   sram_addr_o,
   output logic [TAG_BITS+1:0]   sram_tag_o,
   output logic [LINE_BITS-1:0]  sram_data_o,
   input  logic [TAG_BITS+1:0]   sram_tag_i,
   input  logic [LINE_BITS-1:0]  sram_data_i,
   input  logic                  sram_hit_i,
   output logic                  mem_enable_o,
   output logic                  mem_write_o,
   output logic [31:0]           mem_addr_o,
   output logic [LINE_BITS-1:0]  mem_data_o,
   input  logic [LINE_BITS-1:0]  mem_data_i,
   input  logic                  mem_ack_i,
   output logic [2:0]            state_o
);

   state_t                 state_q, state_d;
   logic [31:0]            addr_q, addr_d;
   logic [31:0]            wdata_q, wdata_d;
   logic                   we_q, we_d;
   logic [LINE_BITS-1:0]   line_q, line_d;      // victim line, then refill line
   logic [TAG_BITS-1:0]    vtag_q, vtag_d;      // victim tag for the write-back address
   logic                   first_q, first_d;    // first cycle of a state

   logic [TAG_BITS-1:0]    req_tag, tag_q;
   logic [IDX_BITS-1:0]    req_idx, idx_q;
   logic [WSEL_W-1:0]      req_word, word_q;
   logic                   hit;
   logic                   unused_addr_bits;

   assign req_tag  = cpu_addr_i[31 -: TAG_BITS];
   assign req_idx  = cpu_addr_i[OFFSET_W +: IDX_BITS];
   assign req_word = cpu_addr_i[2 +: WSEL_W];
   assign tag_q    = addr_q[31 -: TAG_BITS];
   assign idx_q    = addr_q[OFFSET_W +: IDX_BITS];
   assign word_q   = addr_q[2 +: WSEL_W];
   assign unused_addr_bits = ^{cpu_addr_i[1:0], addr_q[1:0]};

   assign hit         = sram_hit_i & sram_tag_i[VALID_BIT];
   assign cpu_stall_o = (state_q != S_IDLE) | (cpu_req_i & ~hit);
   assign state_o     = state_q;
   assign first_d     = (state_d != state_q);

   // SRAM lookup request. Kept apart from the hit-dependent logic so the SRAM's
   // combinational compare never loops back through this block. A store presents
   // the dirty tag word up front; the SRAM only commits it when sram_write_o is set.
   always_comb begin
      sram_enable_o = 1'b0;
      sram_addr_o   = '0;
      sram_tag_o    = '0;
      case (state_q)
         S_IDLE: begin
            if (cpu_req_i) begin
               sram_enable_o = 1'b1;
               sram_addr_o   = req_idx;
               sram_tag_o    = {1'b1, cpu_we_i, req_tag};
            end
         end
         S_MISS: begin
            sram_enable_o = 1'b1;
            sram_addr_o   = idx_q;
            sram_tag_o    = {1'b1, 1'b0, tag_q};
         end
         S_REFILL_DONE: begin
            sram_enable_o = 1'b1;
            sram_addr_o   = idx_q;
            sram_tag_o    = {1'b1, we_q, tag_q};
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      we_d         = we_q;
      line_d       = line_q;
      vtag_d       = vtag_q;
      sram_write_o = 1'b0;
      sram_data_o  = '0;
      cpu_data_o   = '0;
      mem_enable_o = 1'b0;
      mem_write_o  = 1'b0;
      mem_addr_o   = '0;
      mem_data_o   = '0;
      case (state_q)
         S_IDLE: begin
            if (cpu_req_i) begin
               if (hit) begin
                  cpu_data_o = word_select(sram_data_i, req_word);
                  if (cpu_we_i) begin
                     sram_write_o = 1'b1;
                     sram_data_o  = word_merge(sram_data_i, req_word, cpu_data_i);
                  end
               end else begin
                  addr_d  = cpu_addr_i;
                  wdata_d = cpu_data_i;
                  we_d    = cpu_we_i;
                  state_d = S_MISS;
               end
            end
         end
         S_MISS: begin
            // SRAM presents the LRU victim; only a valid+dirty one needs writing back.
            if (sram_tag_i[VALID_BIT] && sram_tag_i[DIRTY_BIT]) begin
               line_d  = sram_data_i;
               vtag_d  = sram_tag_i[TAG_BITS-1:0];
               state_d = S_WRITEBACK;
            end else begin
               state_d = S_REFILL;
            end
         end
         S_WRITEBACK: begin
            mem_enable_o = first_q;
            mem_write_o  = 1'b1;
            mem_addr_o   = {vtag_q, idx_q, {OFFSET_W{1'b0}}};
            mem_data_o   = line_q;
            if (mem_ack_i) state_d = S_REFILL;
         end
         S_REFILL: begin
            mem_enable_o = first_q;
            mem_addr_o   = {tag_q, idx_q, {OFFSET_W{1'b0}}};
            if (mem_ack_i) begin
               line_d  = mem_data_i;
               state_d = S_REFILL_DONE;
            end
         end
         S_REFILL_DONE: begin
            // Store data is merged here so the replayed store in IDLE is a plain rewrite.
            sram_write_o = 1'b1;
            sram_data_o  = we_q ? word_merge(line_q, word_q, wdata_q) : line_q;
            state_d      = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
         line_q  <= '0;
         vtag_q  <= '0;
         first_q <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         we_q    <= we_d;
         line_q  <= line_d;
         vtag_q  <= vtag_d;
         first_q <= first_d;
      end
   end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl with a behavioural 2-way LRU SRAM and a
// latency-programmable memory responder.
module tb_dcache_ctrl;
   import dcache_pkg::*;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic          cpu_req_i, cpu_we_i;
   logic [31:0]   cpu_addr_i, cpu_data_i, cpu_data_o;
   logic          cpu_stall_o;
   logic          sram_enable_o, sram_write_o;
   logic [3:0]    sram_addr_o;
   logic [24:0]   sram_tag_o, sram_tag_i;
   logic [255:0]  sram_data_o, sram_data_i;
   logic          sram_hit_i;
   logic          mem_enable_o, mem_write_o;
   logic [31:0]   mem_addr_o;
   logic [255:0]  mem_data_o, mem_data_i;
   logic          mem_ack_i;
   logic [2:0]    state_o;

   int n_checks = 0;
   int n_pass   = 0;

   dcache_ctrl dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
      .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data_o), .cpu_stall_o(cpu_stall_o),
      .sram_enable_o(sram_enable_o), .sram_write_o(sram_write_o),
      .sram_addr_o(sram_addr_o), .sram_tag_o(sram_tag_o), .sram_data_o(sram_data_o),
      .sram_tag_i(sram_tag_i), .sram_data_i(sram_data_i), .sram_hit_i(sram_hit_i),
      .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
      .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i),
      .state_o(state_o)
   );

   // ---------------- clock ----------------
   always #5 clk_i = ~clk_i;

   // ---------------- SRAM model: 2 ways x 16 sets, LRU victim on miss ----------------
   logic [24:0]  tag_mem  [2][16];
   logic [255:0] data_mem [2][16];
   logic         lru      [16];    // way to evict next
   logic         mdl_clr;
   logic         m_hit;
   logic         m_way;

   always_comb begin
      m_hit = 1'b0;
      m_way = lru[sram_addr_o];
      for (int w = 0; w < 2; w++) begin
         if (tag_mem[w][sram_addr_o][24] && tag_mem[w][sram_addr_o][22:0] == sram_tag_o[22:0]) begin
            m_hit = 1'b1;
            m_way = w[0];
         end
      end
      sram_hit_i  = m_hit;
      sram_tag_i  = tag_mem[m_way][sram_addr_o];
      sram_data_i = data_mem[m_way][sram_addr_o];
   end

   always @(posedge clk_i) begin
      if (mdl_clr) begin
         for (int s = 0; s < 16; s++) begin
            lru[s] <= 1'b0;
            for (int w = 0; w < 2; w++) begin
               tag_mem[w][s]  <= '0;
               data_mem[w][s] <= '0;
            end
         end
      end else if (sram_enable_o) begin
         if (sram_write_o) begin
            tag_mem[m_way][sram_addr_o]  <= sram_tag_o;
            data_mem[m_way][sram_addr_o] <= sram_data_o;
         end
         if (sram_write_o || m_hit) lru[sram_addr_o] <= ~m_way;
      end
   end

   // ---------------- driver / check tasks ----------------
   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   function automatic logic [255:0] mk_line(input logic [31:0] base);
      logic [255:0] l;
      for (int i = 0; i < 8; i++) l[i*32 +: 32] = base + i;
      return l;
   endfunction

   // Issue a request that must miss and walk it to completion, answering memory
   // requests 'lat' cycles after each pulse (0 = same cycle). exp_stall counts every
   // stalled cycle including the detection cycle in IDLE.
   task automatic run_miss(input logic we, input logic [31:0] addr, input logic [31:0] data,
                           input int lat, input logic exp_wb, input logic [31:0] wb_addr,
                           input logic [255:0] wb_line, input logic [255:0] rf_line,
                           input logic [31:0] exp_rdata, input int exp_stall);
      int stalls, pulses, cd;
      mem_data_i = rf_line;
      cpu_req_i  = 1'b1;
      cpu_we_i   = we;
      cpu_addr_i = addr;
      cpu_data_i = data;
      #1;
      check("miss_detect_stall", cpu_stall_o, 1);
      stalls = 0;
      pulses = 0;
      cd     = -1;
      for (int c = 0; c < 200; c++) begin
         if (!cpu_stall_o) break;
         stalls++;
         if (mem_enable_o) begin
            pulses++;
            if (exp_wb && pulses == 1) begin
               check("wb_write", mem_write_o, 1);
               check("wb_addr", mem_addr_o, wb_addr);
               check("wb_data", mem_data_o, wb_line);
            end else begin
               check("rf_write", mem_write_o, 0);
               check("rf_addr", mem_addr_o, {addr[31:5], 5'b0});
            end
            cd = lat;
         end
         if (cd >= 0) begin
            if (cd == 0) mem_ack_i = 1'b1;
            cd--;
         end
         @(posedge clk_i);
         #1;
         mem_ack_i = 1'b0;
         #1;
      end
      check("stall_cycles", stalls, exp_stall);
      check("mem_pulses", pulses, exp_wb ? 2 : 1);
      check("replay_state", state_o, S_IDLE);
      if (!we) check("replay_load_data", cpu_data_o, exp_rdata);
      else     check("replay_store_write", sram_write_o, 1);
      step();
      cpu_req_i = 1'b0;
      cpu_we_i  = 1'b0;
      #1;
   endtask

   task automatic hit_load(input logic [31:0] addr, input logic [31:0] exp_rdata);
      cpu_req_i  = 1'b1;
      cpu_we_i   = 1'b0;
      cpu_addr_i = addr;
      #1;
      check("hit_load_stall", cpu_stall_o, 0);
      check("hit_load_data", cpu_data_o, exp_rdata);
      step();
      cpu_req_i = 1'b0;
      #1;
   endtask

   // ---------------- directed sequence ----------------
   logic [255:0] line_a, line_am, line_b, line_c, line_d, line_e, line_f, line_g, line_h;
   logic         seen;

   initial begin
      line_a = mk_line(32'hA000_0000);
      line_a[31:0] = 32'hDEAD_BEEF;
      line_am = line_a;
      line_am[63:32] = 32'h1234_5678;
      line_b = mk_line(32'hB000_0000);
      line_c = mk_line(32'hC000_0000);
      line_d = mk_line(32'hD000_0000);
      line_e = mk_line(32'hE000_0000);
      line_f = mk_line(32'hF000_0000);
      line_g = mk_line(32'h7000_0000);
      line_h = mk_line(32'h5000_0000);

      // reset
      rst_i = 1'b1; mdl_clr = 1'b1;
      cpu_req_i = 1'b0; cpu_we_i = 1'b0; cpu_addr_i = '0; cpu_data_i = '0;
      mem_data_i = '0; mem_ack_i = 1'b0;
      step(); step();
      #1;
      check("rst_stall", cpu_stall_o, 0);
      check("rst_mem_enable", mem_enable_o, 0);
      check("rst_sram_enable", sram_enable_o, 0);
      check("rst_sram_write", sram_write_o, 0);
      check("rst_sram_tag", sram_tag_o, 0);
      check("rst_mem_addr", mem_addr_o, 0);
      check("rst_cpu_data", cpu_data_o, 0);
      check("rst_state", state_o, S_IDLE);
      step();
      rst_i = 1'b0; mdl_clr = 1'b0;
      step();

      // cold read miss, latency 3: 1 detect + 1 MISS + (1+3) REFILL + 1 DONE
      run_miss(1'b0, 32'h0000_0040, 32'h0, 3, 1'b0, 32'h0, '0, line_a, 32'hDEAD_BEEF, 7);

      // write hit, then load it back
      cpu_req_i = 1'b1; cpu_we_i = 1'b1; cpu_addr_i = 32'h0000_0044; cpu_data_i = 32'h1234_5678;
      #1;
      check("whit_stall", cpu_stall_o, 0);
      check("whit_write", sram_write_o, 1);
      check("whit_tag", sram_tag_o, 25'h180_0000);
      check("whit_data", sram_data_o, line_am);
      step();
      cpu_req_i = 1'b0; cpu_we_i = 1'b0;
      cpu_req_i = 1'b1; cpu_addr_i = 32'h0000_0044;
      #1;
      check("whit_dirty_bits", sram_tag_i[24:23], 2'b11);
      step();
      cpu_req_i = 1'b0;
      #1;
      hit_load(32'h0000_0044, 32'h1234_5678);

      // dirty eviction in set 2: fill other way (latency 0), then evict 0x40
      run_miss(1'b0, 32'h0000_0240, 32'h0, 0, 1'b0, 32'h0, '0, line_b, 32'hB000_0000, 4);
      run_miss(1'b0, 32'h0000_0440, 32'h0, 10, 1'b1, 32'h0000_0040, line_am, line_c,
               32'hC000_0000, 25);
      hit_load(32'h0000_0244, 32'hB000_0001);

      // clean eviction in set 5: no write-back pulse
      run_miss(1'b0, 32'h0000_00A0, 32'h0, 1, 1'b0, 32'h0, '0, line_d, 32'hD000_0000, 5);
      run_miss(1'b0, 32'h0000_02A0, 32'h0, 1, 1'b0, 32'h0, '0, line_e, 32'hE000_0000, 5);
      run_miss(1'b0, 32'h0000_04A8, 32'h0, 1, 1'b0, 32'h0, '0, line_f, 32'hF000_0002, 5);

      // store miss: data merged into the refilled line, neighbours untouched
      run_miss(1'b1, 32'h0000_0088, 32'hCAFE_F00D, 0, 1'b0, 32'h0, '0, line_g, 32'h0, 4);
      cpu_req_i = 1'b1; cpu_addr_i = 32'h0000_0088;
      #1;
      check("smiss_dirty_bits", sram_tag_i[24:23], 2'b11);
      check("smiss_word", cpu_data_o, 32'hCAFE_F00D);
      step();
      cpu_req_i = 1'b0;
      #1;
      hit_load(32'h0000_008C, 32'h7000_0003);

      // stray ack in IDLE is ignored
      mem_ack_i = 1'b1;
      #1;
      check("stray_ack_write", sram_write_o, 0);
      step();
      mem_ack_i = 1'b0;
      #1;
      check("stray_ack_state", state_o, S_IDLE);
      check("stray_ack_mem_en", mem_enable_o, 0);
      hit_load(32'h0000_0088, 32'hCAFE_F00D);

      // reset during REFILL; a late ack must not write the SRAM
      mem_data_i = line_h;
      cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h1000_0000;
      #1;
      seen = 1'b0;
      for (int c = 0; c < 20; c++) begin
         if (mem_enable_o) begin
            seen = 1'b1;
            break;
         end
         step();
         #1;
      end
      check("rstmid_pulse_seen", seen, 1);
      check("rstmid_state_refill", state_o, S_REFILL);
      step();
      rst_i = 1'b1; cpu_req_i = 1'b0;
      #1;
      check("rstmid_state", state_o, S_IDLE);
      check("rstmid_stall", cpu_stall_o, 0);
      check("rstmid_mem_enable", mem_enable_o, 0);
      check("rstmid_mem_addr", mem_addr_o, 0);
      check("rstmid_sram_enable", sram_enable_o, 0);
      step();
      rst_i = 1'b0; mem_ack_i = 1'b1;
      #1;
      check("rstmid_ack_write", sram_write_o, 0);
      step();
      mem_ack_i = 1'b0;
      #1;
      check("rstmid_ack_state", state_o, S_IDLE);
      // the line must still be absent: this is a full clean miss again
      run_miss(1'b0, 32'h1000_0000, 32'h0, 2, 1'b0, 32'h0, '0, line_h, 32'h5000_0000, 6);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
